// File: rtl/kalman_sequencer.sv
// Iteration controller for the Kalman filter core: prediction -> gain -> update
// through start/ready handshakes, with a per-phase watchdog and overrun accounting.
module kalman_sequencer #(
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 enable,
  input  logic                 sample_strobe,
  input  logic                 clear,
  input  logic                 ready_Prediction,
  input  logic                 ready_Gain,
  input  logic                 ready_Update,
  output logic                 Start_Prediction,
  output logic                 Start_Gain,
  output logic                 Start_Update,
  output logic                 busy,
  output logic                 iter_done,
  output logic                 error,
  output logic [1:0]           err_phase,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic [CNT_WIDTH-1:0] overrun_count
);

  typedef enum logic [3:0] {
    IDLE,
    PRED_START,
    PRED_WAIT,
    GAIN_START,
    GAIN_WAIT,
    UPD_START,
    UPD_WAIT,
    DONE,
    ERROR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 rdy_pred_p1;
  logic                 rdy_gain_p1;
  logic                 rdy_upd_p1;
  logic                 pred_rise;
  logic                 gain_rise;
  logic                 upd_rise;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic                 wd_expired;
  logic                 in_iter;
  logic                 in_start;
  logic                 in_wait;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] wrap_inc(input logic [CNT_WIDTH-1:0] v);
    return v + 1'b1;
  endfunction

  function automatic logic [1:0] phase_code(input state_t s);
    case (s)
      PRED_WAIT: return 2'd1;
      GAIN_WAIT: return 2'd2;
      UPD_WAIT:  return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  // A ready counts only on its 0->1 transition, so a level left high from a
  // previous iteration cannot advance the sequence.
  assign pred_rise  = ready_Prediction & ~rdy_pred_p1;
  assign gain_rise  = ready_Gain       & ~rdy_gain_p1;
  assign upd_rise   = ready_Update     & ~rdy_upd_p1;
  assign wd_expired = (wd_cnt == WD_LAST);

  assign in_iter  = (state != IDLE) && (state != ERROR);
  assign in_start = (state == PRED_START) || (state == GAIN_START) || (state == UPD_START);
  assign in_wait  = (state == PRED_WAIT)  || (state == GAIN_WAIT)  || (state == UPD_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (enable && sample_strobe) state_nxt = PRED_START;
      PRED_START: state_nxt = PRED_WAIT;
      PRED_WAIT: begin
        if (pred_rise)       state_nxt = GAIN_START;
        else if (wd_expired) state_nxt = ERROR;
      end
      GAIN_START: state_nxt = GAIN_WAIT;
      GAIN_WAIT: begin
        if (gain_rise)       state_nxt = UPD_START;
        else if (wd_expired) state_nxt = ERROR;
      end
      UPD_START:  state_nxt = UPD_WAIT;
      UPD_WAIT: begin
        if (upd_rise)        state_nxt = DONE;
        else if (wd_expired) state_nxt = ERROR;
      end
      DONE:       state_nxt = IDLE;
      ERROR:      if (clear) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: state, ready history, watchdog and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rdy_pred_p1   <= 1'b0;
      rdy_gain_p1   <= 1'b0;
      rdy_upd_p1    <= 1'b0;
      wd_cnt        <= '0;
      err_phase     <= 2'd0;
      overrun       <= 1'b0;
      iter_count    <= '0;
      overrun_count <= '0;
    end else if (clk_en) begin
      state       <= state_nxt;
      rdy_pred_p1 <= ready_Prediction;
      rdy_gain_p1 <= ready_Gain;
      rdy_upd_p1  <= ready_Update;

      if (in_wait)       wd_cnt <= wrap_inc(wd_cnt);
      else if (in_start) wd_cnt <= '0;
      else               wd_cnt <= '0;

      if ((state != ERROR) && (state_nxt == ERROR))
        err_phase <= phase_code(state);
      else if ((state == ERROR) && clear)
        err_phase <= 2'd0;

      // A dropped strobe outranks a coincident clear.
      if (in_iter && sample_strobe)
        overrun <= 1'b1;
      else if (clear)
        overrun <= 1'b0;

      if (in_iter && sample_strobe)
        overrun_count <= sat_inc(overrun_count);

      if (state == DONE)
        iter_count <= wrap_inc(iter_count);
    end
  end

  assign Start_Prediction = (state == PRED_START);
  assign Start_Gain       = (state == GAIN_START);
  assign Start_Update     = (state == UPD_START);
  assign iter_done        = (state == DONE);
  assign error            = (state == ERROR);
  assign busy             = in_iter;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Directed bench for kalman_sequencer: a scoreboard of expected start/done
// events plus cycle-level checks of handshakes, watchdog, overrun and reset.
module tb_kalman_sequencer;

  localparam int TIMEOUT   = 16;
  localparam int CNT_WIDTH = 16;

  logic                 clk;
  logic                 reset;
  logic                 clk_en;
  logic                 enable;
  logic                 sample_strobe;
  logic                 clear;
  logic                 ready_Prediction;
  logic                 ready_Gain;
  logic                 ready_Update;
  logic                 Start_Prediction;
  logic                 Start_Gain;
  logic                 Start_Update;
  logic                 busy;
  logic                 iter_done;
  logic                 error;
  logic [1:0]           err_phase;
  logic                 overrun;
  logic [CNT_WIDTH-1:0] iter_count;
  logic [CNT_WIDTH-1:0] overrun_count;

  int tests = 0;
  int fails = 0;
  int exp_iters = 0;
  int exp_q[$];

  kalman_sequencer #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .enable           (enable),
    .sample_strobe    (sample_strobe),
    .clear            (clear),
    .ready_Prediction (ready_Prediction),
    .ready_Gain       (ready_Gain),
    .ready_Update     (ready_Update),
    .Start_Prediction (Start_Prediction),
    .Start_Gain       (Start_Gain),
    .Start_Update     (Start_Update),
    .busy             (busy),
    .iter_done        (iter_done),
    .error            (error),
    .err_phase        (err_phase),
    .overrun          (overrun),
    .iter_count       (iter_count),
    .overrun_count    (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic start_of(input int ph);
    case (ph)
      1:       return Start_Prediction;
      2:       return Start_Gain;
      default: return Start_Update;
    endcase
  endfunction

  task automatic set_ready(input int ph, input logic v);
    case (ph)
      1:       ready_Prediction = v;
      2:       ready_Gain = v;
      default: ready_Update = v;
    endcase
  endtask

  task automatic push_iter();
    for (int i = 1; i <= 4; i++) exp_q.push_back(i);
  endtask

  task automatic launch();
    enable = 1'b1;
    sample_strobe = 1'b1;
    step(1);
    sample_strobe = 1'b0;
  endtask

  task automatic wait_start(input int ph);
    int n = 0;
    while (start_of(ph) !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("start_seen", {31'd0, start_of(ph)}, 1);
  endtask

  // Answer phase ph with a one-cycle ready pulse sampled d+1 edges after its start.
  task automatic respond(input int ph, input int d);
    wait_start(ph);
    step(1);
    chk("start_width", {31'd0, start_of(ph)}, 0);
    if (d > 1) step(d - 1);
    set_ready(ph, 1'b1);
    step(1);
    set_ready(ph, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (iter_done !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("iter_done_seen", {31'd0, iter_done}, 1);
    exp_iters++;
    step(1);
    chk("iter_done_width", {31'd0, iter_done}, 0);
    chk("iter_count", iter_count, exp_iters);
    chk("busy_after_done", {31'd0, busy}, 0);
  endtask

  // Scoreboard: each rising start/done pulse is matched against the expected order.
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    prev = 4'b0;
    forever begin
      @(negedge clk);
      cur = {iter_done, Start_Update, Start_Gain, Start_Prediction};
      for (int b = 0; b < 4; b++) begin
        if (cur[b] && !prev[b]) begin
          if (exp_q.size() == 0) chk("unexpected_event", b + 1, 0);
          else                   chk("event_order", b + 1, exp_q.pop_front());
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int w;
    reset = 1'b0;
    clk_en = 1'b1;
    enable = 1'b0;
    sample_strobe = 1'b0;
    clear = 1'b0;
    ready_Prediction = 1'b0;
    ready_Gain = 1'b0;
    ready_Update = 1'b0;

    step(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_start_p", {31'd0, Start_Prediction}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_err_phase", {30'd0, err_phase}, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_overrun_count", overrun_count, 0);
    reset = 1'b1;
    step(2);

    // Minimum-length iteration, checked edge by edge.
    push_iter();
    launch();
    chk("min_start_p", {31'd0, Start_Prediction}, 1);
    chk("min_busy", {31'd0, busy}, 1);
    step(1);
    chk("min_start_p_low", {31'd0, Start_Prediction}, 0);
    ready_Prediction = 1'b1;
    step(1);
    chk("min_start_g", {31'd0, Start_Gain}, 1);
    ready_Prediction = 1'b0;
    step(1);
    ready_Gain = 1'b1;
    step(1);
    chk("min_start_u", {31'd0, Start_Update}, 1);
    ready_Gain = 1'b0;
    step(1);
    ready_Update = 1'b1;
    step(1);
    chk("min_iter_done", {31'd0, iter_done}, 1);
    ready_Update = 1'b0;
    step(1);
    exp_iters = 1;
    chk("min_iter_done_low", {31'd0, iter_done}, 0);
    chk("min_iter_count", iter_count, 1);
    step(2);

    // Nominal iteration, each ready rising 3 cycles after its start.
    push_iter();
    launch();
    respond(1, 3);
    respond(2, 3);
    respond(3, 3);
    wait_done();
    step(2);

    // Stale ready_Prediction must not advance PRED_WAIT.
    ready_Prediction = 1'b1;
    step(2);
    push_iter();
    launch();
    step(6);
    chk("stale_busy", {31'd0, busy}, 1);
    chk("stale_no_gain", {31'd0, Start_Gain}, 0);
    ready_Prediction = 1'b0;
    step(2);
    ready_Prediction = 1'b1;
    step(1);
    chk("stale_gain_after_rise", {31'd0, Start_Gain}, 1);
    ready_Prediction = 1'b0;
    respond(2, 2);
    respond(3, 2);
    wait_done();
    step(2);

    // Watchdog on the gain phase.
    exp_q.push_back(1);
    exp_q.push_back(2);
    launch();
    respond(1, 1);
    wait_start(2);
    step(1);
    step(TIMEOUT - 1);
    chk("wd_not_yet", {31'd0, error}, 0);
    chk("wd_busy_before", {31'd0, busy}, 1);
    step(1);
    chk("wd_error", {31'd0, error}, 1);
    chk("wd_err_phase", {30'd0, err_phase}, 2);
    chk("wd_busy", {31'd0, busy}, 0);
    ready_Gain = 1'b1;
    step(2);
    ready_Gain = 1'b0;
    chk("err_ignores_ready", {31'd0, error}, 1);
    sample_strobe = 1'b1;
    step(2);
    sample_strobe = 1'b0;
    chk("err_strobe_not_counted", overrun_count, 0);
    chk("err_no_overrun", {31'd0, overrun}, 0);
    chk("err_stays", {31'd0, error}, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_error", {31'd0, error}, 0);
    chk("clr_err_phase", {30'd0, err_phase}, 0);
    chk("clr_busy", {31'd0, busy}, 0);
    chk("wd_queue_drained", exp_q.size(), 0);
    step(2);

    // Three strobes during one iteration.
    push_iter();
    enable = 1'b1;
    sample_strobe = 1'b1;
    step(4);
    sample_strobe = 1'b0;
    chk("ovr_flag", {31'd0, overrun}, 1);
    chk("ovr_count", overrun_count, 3);
    ready_Prediction = 1'b1;
    step(1);
    ready_Prediction = 1'b0;
    respond(2, 2);
    respond(3, 2);
    wait_done();
    step(5);
    chk("ovr_single_iter", exp_q.size(), 0);
    chk("ovr_idle", {31'd0, busy}, 0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 0);
    chk("ovr_count_kept", overrun_count, 3);

    // Strobes with enable low are ignored.
    enable = 1'b0;
    sample_strobe = 1'b1;
    step(3);
    sample_strobe = 1'b0;
    chk("dis_busy", {31'd0, busy}, 0);
    chk("dis_count", overrun_count, 3);
    step(1);

    // clk_en low for 4 cycles while in PRED_START.
    push_iter();
    launch();
    w = 0;
    if (Start_Prediction === 1'b1) w++;
    clk_en = 1'b0;
    repeat (4) begin
      step(1);
      if (Start_Prediction === 1'b1) w++;
    end
    clk_en = 1'b1;
    step(1);
    chk("cen_start_p_low", {31'd0, Start_Prediction}, 0);
    chk("cen_stretch", w, 5);
    step(1);
    ready_Prediction = 1'b1;
    step(1);
    ready_Prediction = 1'b0;
    respond(2, 2);
    respond(3, 2);
    wait_done();
    step(2);

    // Strobe and clear together mid-iteration, then async reset in UPD_WAIT.
    push_iter();
    launch();
    respond(1, 2);
    respond(2, 2);
    wait_start(3);
    step(1);
    sample_strobe = 1'b1;
    clear = 1'b1;
    step(1);
    sample_strobe = 1'b0;
    clear = 1'b0;
    chk("setwins_flag", {31'd0, overrun}, 1);
    chk("setwins_count", overrun_count, 4);
    chk("upd_wait_busy", {31'd0, busy}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_start_u", {31'd0, Start_Update}, 0);
    chk("arst_iter_done", {31'd0, iter_done}, 0);
    chk("arst_overrun", {31'd0, overrun}, 0);
    chk("arst_iter_count", iter_count, 0);
    chk("arst_overrun_count", overrun_count, 0);
    exp_q.delete();
    exp_iters = 0;
    reset = 1'b1;
    step(2);
    push_iter();
    launch();
    respond(1, 1);
    respond(2, 1);
    respond(3, 1);
    wait_done();

    step(3);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
